// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between the sixteen requesters and the arbiter.
// The requester side drives req and observes the grant outputs.
// The arbiter side samples req and drives the grant outputs.
interface rr_grant_arbiter_if;
  logic [15:0] req;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;

  // Requester side.
  modport master (
    output req,
    input  grant,
    input  grant_idx,
    input  grant_valid
  );

  // Arbiter side.
  modport slave (
    input  req,
    output grant,
    output grant_idx,
    output grant_valid
  );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Sixteen-way round-robin arbiter with a registered one-hot grant and an
// optional hold limit that lets a waiting requester preempt a long owner.
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_grant_arbiter_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Preemption fires when the counter reaches MAX_HOLD-1, so the owner sees
  // exactly MAX_HOLD grant cycles before the switching edge.
  localparam logic       PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t      state_reg, state_next;
  logic [3:0]  ptr_reg, ptr_next;
  logic [7:0]  hold_cnt_reg, hold_cnt_next;
  logic [3:0]  idx_reg, idx_next;
  logic        valid_reg, valid_next;
  logic [15:0] grant_reg, grant_next;

  logic [15:0] owner_bit;
  logic [15:0] others;
  logic [15:0] pick_mask;
  logic        pick_found;
  logic [3:0]  pick_idx;
  logic [15:0] pick_onehot;

  // First set bit of mask, scanning upward from start with 15 -> 0 wrap.
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic logic [4:0] pick(input logic [15:0] mask, input logic [3:0] start);
    logic [4:0] result;
    logic [3:0] k;
    result = 5'd0;
    for (int off = 15; off >= 0; off--) begin
      k = start + 4'(off);
      if (mask[k]) begin
        result = {1'b1, k};
      end
    end
    return result;
  endfunction

  // Mask off the current owner so handoff and preemption only consider waiters.
  assign owner_bit = 16'h0001 << idx_reg;
  assign others    = bus.req & ~owner_bit;

  // From IDLE every requester competes; while owning only the others do.
  assign pick_mask = (state_reg == IDLE) ? bus.req : others;
  assign {pick_found, pick_idx} = pick(pick_mask, ptr_reg);

  // One-hot decode of the winner, loaded into the grant flops directly.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_idx == 4'(gi));
    end
  endgenerate

  // Next-state and next-output decision for the IDLE/OWN controller.
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    grant_next    = grant_reg;

    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          state_next    = OWN;
          idx_next      = pick_idx;
          valid_next    = 1'b1;
          grant_next    = pick_onehot;
          ptr_next      = pick_idx + 4'd1;
          hold_cnt_next = 8'd0;
        end
      end

      OWN: begin
        if (!bus.req[idx_reg]) begin
          // Owner released: hand off with no idle gap, or go idle.
          if (pick_found) begin
            idx_next      = pick_idx;
            grant_next    = pick_onehot;
            ptr_next      = pick_idx + 4'd1;
            hold_cnt_next = 8'd0;
          end else begin
            state_next = IDLE;
            valid_next = 1'b0;
            grant_next = 16'h0000;
          end
        end else if (PREEMPT_EN && (hold_cnt_reg == HOLD_LAST) && pick_found) begin
          // Hold limit reached with someone waiting: owner keeps its request
          // and rejoins the rotation.
          idx_next      = pick_idx;
          grant_next    = pick_onehot;
          ptr_next      = pick_idx + 4'd1;
          hold_cnt_next = 8'd0;
        end else if (hold_cnt_reg != 8'hFF) begin
          hold_cnt_next = hold_cnt_reg + 8'd1;
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        grant_next = 16'h0000;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= 4'd0;
      hold_cnt_reg <= 8'd0;
      idx_reg      <= 4'd0;
      valid_reg    <= 1'b0;
      grant_reg    <= 16'h0000;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      hold_cnt_reg <= hold_cnt_next;
      idx_reg      <= idx_next;
      valid_reg    <= valid_next;
      grant_reg    <= grant_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.grant_idx   = idx_reg;
  assign bus.grant_valid = valid_reg;

endmodule
